pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Multi-thread program-counter unit for the fetch stage. Holds one PC per hardware
//  thread and picks one enabled thread per cycle, round-robin. Presents that thread's
//  PC to instruction memory, then post-increments it. Generalises the single-PC register
//  with per-thread redirect, a thread-enable mask, a parametrised reset vector and increment,
//  and a wrap indication.
// PARAMETERS
//  ADDR_WIDTH    12   PC width in bits; all PC arithmetic is modulo 2**ADDR_WIDTH
//  NUM_THREADS   4    number of PCs/threads (>=1); TID_W = max(1,$clog2(NUM_THREADS))
//  INSTR_BYTES   4    PC increment per issued fetch; power of two
//  RESET_VECTOR  0    value loaded into every PC on reset; multiple of INSTR_BYTES
//  TRAP_VECTOR   'h100 misalignment trap target (used only with PC_MISALIGN_TRAP_EN)
// PORTS
//  clk             in   1           clock, all state updates on posedge
//  reset           in   1           synchronous, active-high; priority over all inputs
//  stall           in   1           hazard-unit stall: hold fetch outputs, no issue
//  thread_enable   in   NUM_THREADS per-thread eligibility mask for scheduling
//  redirect_valid  in   1           load redirect_pc into thread redirect_tid
//  redirect_tid    in   TID_W       thread to redirect (branch/jump/flush target)
//  redirect_pc     in   ADDR_WIDTH  new PC for redirect_tid
//  fetch_valid     out  1           fetch_pc/fetch_tid are a valid request
//  fetch_tid       out  TID_W       thread of the current fetch
//  fetch_pc        out  ADDR_WIDTH  address to instruction memory
//  pc_wrap         out  1           1-cycle pulse: issued thread's increment overflowed
//  misalign_trap   out  1           (PC_MISALIGN_TRAP_EN only) 1-cycle trap pulse
// BEHAVIOUR
//  - Reset (sync): pc[i]=RESET_VECTOR for all i; fetch_valid=0, fetch_tid=0,
//    fetch_pc=RESET_VECTOR, pc_wrap=0, misalign_trap=0; rr pointer last=NUM_THREADS-1,
//    so thread 0 is first. Reset asserted mid-operation discards all state next edge.
//  - Outputs are registered; a thread selected at edge N appears on fetch_* after edge N.
//  - Scheduling (stall=0): sel = first enabled thread scanning last+1, last+2, ... mod
//    NUM_THREADS, with last included as the final candidate. On the edge: fetch_valid<=1,
//    fetch_tid<=sel, fetch_pc<=pc[sel], pc[sel]<=pc[sel]+INSTR_BYTES, last<=sel.
//  - No enabled thread (stall=0): fetch_valid<=0, pc[] and last unchanged.
//  - stall=1: fetch_valid/tid/pc hold, last holds, no increment, pc_wrap<=0.
//  - Redirect: applied on the edge regardless of stall; pc[redirect_tid]<=redirect_pc.
//    If stall=0 and redirect_tid==sel, bypass: fetch_pc<=redirect_pc and
//    pc[sel]<=redirect_pc+INSTR_BYTES. With stall=1 no bypass; held outputs unchanged.
//  - Redirect of a disabled thread is legal; its PC updates and it issues when enabled.
//  - Wrap: pc_wrap<=1 on the issuing edge iff pc[sel]+INSTR_BYTES >= 2**ADDR_WIDTH
//    (bypass: test redirect_pc). Else 0. The PC wraps modulo 2**ADDR_WIDTH.
//  - Alignment: without the macro, the low log2(INSTR_BYTES) bits of redirect_pc are
//    forced to 0 before use. Issued fetch_pc is always INSTR_BYTES-aligned.
// CONFIGURATION
//  PC_MISALIGN_TRAP_EN defined: a redirect with nonzero low log2(INSTR_BYTES) bits loads
//    TRAP_VECTOR instead, and the bypass also uses TRAP_VECTOR. misalign_trap pulses 1
//    for one cycle after the edge. Its thread is reported as redirect_tid through
//    fetch_tid only if bypassed. misalign_trap is held 0 under reset.
//  Not defined: misalign_trap port absent; misaligned redirect_pc is silently aligned down.
// TESTING (ADDR_WIDTH=12, NUM_THREADS=4, INSTR_BYTES=4, RESET_VECTOR=0)
//  1 reset, enable=4'b1111 -> (tid,pc): (0,0x000),(1,0x000),(2,0x000),(3,0x000),(0,0x004)
//  2 enable=4'b0101 -> tids 0,2,0,2; then enable=0 -> fetch_valid=0, PCs frozen
//  3 stall 3 cycles + redirect tid1->0x200 mid-stall -> outputs held; tid1 later issues 0x200
//  4 redirect tid2->0x300 on edge tid2 is selected -> fetch_pc=0x300; tid2's next=0x304
//  5 pc[0]=0xFFC issued -> pc_wrap=1 for 1 cycle; tid0's next fetch_pc=0x000
//  6 redirect tid0->0x202: with EN -> fetch 0x100, misalign_trap=1; without -> 0x200

Source files
------------

// File: rtl/pc_sequencer.sv
// Multi-thread round-robin PC unit for the fetch stage.
// Optional PC_MISALIGN_TRAP_EN: misaligned redirects trap to TRAP_VECTOR.
module pc_sequencer #(
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned NUM_THREADS  = 4,
  parameter int unsigned INSTR_BYTES  = 4,
  parameter int unsigned RESET_VECTOR = 0,
  parameter int unsigned TRAP_VECTOR  = 'h100,
  localparam int unsigned TID_W =
    (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic [NUM_THREADS-1:0] thread_enable,
  input  logic                  redirect_valid,
  input  logic [TID_W-1:0]      redirect_tid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  fetch_valid,
  output logic [TID_W-1:0]      fetch_tid,
  output logic [ADDR_WIDTH-1:0] fetch_pc,
  output logic                  pc_wrap
`ifdef PC_MISALIGN_TRAP_EN
  ,
  output logic                  misalign_trap
`endif
);

  localparam logic [ADDR_WIDTH-1:0] LOW_MASK =
    ADDR_WIDTH'(INSTR_BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] RST_PC =
    ADDR_WIDTH'(RESET_VECTOR);
  localparam logic [ADDR_WIDTH:0] INC =
    (ADDR_WIDTH+1)'(INSTR_BYTES);

  logic [ADDR_WIDTH-1:0] pc [NUM_THREADS];
  logic [TID_W-1:0]      last;
  logic [TID_W-1:0]      sel;
  logic                  found;
  logic [ADDR_WIDTH-1:0] rd_pc;
  logic                  bypass;
  logic [ADDR_WIDTH-1:0] base;
  logic [ADDR_WIDTH:0]   sum;
  logic                  rd_ok;

`ifdef PC_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = |(redirect_pc & LOW_MASK);
  assign rd_pc = misaligned ? ADDR_WIDTH'(TRAP_VECTOR)
                            : redirect_pc;
`else
  assign rd_pc = redirect_pc & ~LOW_MASK;
`endif

  // Scan last+1 .. last+NUM_THREADS so last is the final candidate.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int k = 1; k <= int'(NUM_THREADS); k++) begin
      int idx;
      idx = (int'(last) + k) % int'(NUM_THREADS);
      if (!found && thread_enable[idx]) begin
        found = 1'b1;
        sel   = TID_W'(idx);
      end
    end
  end

  assign rd_ok  = int'(redirect_tid) < int'(NUM_THREADS);
  assign bypass = redirect_valid && (redirect_tid == sel);
  assign base   = bypass ? rd_pc : pc[sel];
  assign sum    = {1'b0, base} + INC;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_THREADS); i++)
        pc[i] <= RST_PC;
      last        <= TID_W'(NUM_THREADS - 1);
      fetch_valid <= 1'b0;
      fetch_tid   <= '0;
      fetch_pc    <= RST_PC;
      pc_wrap     <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      misalign_trap <= 1'b0;
`endif
    end else begin
`ifdef PC_MISALIGN_TRAP_EN
      misalign_trap <= redirect_valid && misaligned;
`endif
      pc_wrap <= 1'b0;
      if (redirect_valid && rd_ok)
        pc[redirect_tid] <= rd_pc;
      // The issue write comes last so a bypassed redirect gets +INC.
      if (!stall) begin
        if (found) begin
          fetch_valid <= 1'b1;
          fetch_tid   <= sel;
          fetch_pc    <= base;
          pc[sel]     <= sum[ADDR_WIDTH-1:0];
          last        <= sel;
          pc_wrap     <= sum[ADDR_WIDTH];
        end else begin
          fetch_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer
// (ADDR_WIDTH=12, NUM_THREADS=4, INSTR_BYTES=4).
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [3:0]  thread_enable;
  logic        redirect_valid;
  logic [1:0]  redirect_tid;
  logic [11:0] redirect_pc;
  logic        fetch_valid;
  logic [1:0]  fetch_tid;
  logic [11:0] fetch_pc;
  logic        pc_wrap;
`ifdef PC_MISALIGN_TRAP_EN
  logic        misalign_trap;
`endif

  int checks = 0;
  int errors = 0;

  pc_sequencer #(
    .ADDR_WIDTH(12), .NUM_THREADS(4), .INSTR_BYTES(4),
    .RESET_VECTOR(0), .TRAP_VECTOR('h100)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .thread_enable(thread_enable),
    .redirect_valid(redirect_valid),
    .redirect_tid(redirect_tid),
    .redirect_pc(redirect_pc),
    .fetch_valid(fetch_valid), .fetch_tid(fetch_tid),
    .fetch_pc(fetch_pc), .pc_wrap(pc_wrap)
`ifdef PC_MISALIGN_TRAP_EN
    , .misalign_trap(misalign_trap)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] en);
    reset = 1'b1; stall = 1'b0; thread_enable = en;
    redirect_valid = 1'b0; redirect_tid = '0; redirect_pc = '0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(4'b1111);
    checks++;
    if (fetch_valid !== 1'b0 || fetch_tid !== 2'd0 ||
        fetch_pc !== 12'h000 || pc_wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset v=%b tid=%0d pc=%h wrap=%b want 0 0 000 0",
               fetch_valid, fetch_tid, fetch_pc, pc_wrap);
    end
    // Mid-operation reset discards advanced PCs and rr pointer.
    step(); step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    checks++;
    if (fetch_valid !== 1'b1 || fetch_tid !== 2'd0 ||
        fetch_pc !== 12'h000) begin
      errors++;
      $display("FAIL reset_mid v=%b tid=%0d pc=%h want 1 0 000",
               fetch_valid, fetch_tid, fetch_pc);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0]  et [5];
    logic [11:0] ep [5];
    et = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    ep = '{12'h000, 12'h000, 12'h000, 12'h000, 12'h004};
    do_reset(4'b1111);
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (fetch_valid !== 1'b1 || fetch_tid !== et[i] ||
          fetch_pc !== ep[i] || pc_wrap !== 1'b0) begin
        errors++;
        $display("FAIL rr[%0d] v=%b tid=%0d pc=%h want tid=%0d pc=%h",
                 i, fetch_valid, fetch_tid, fetch_pc, et[i], ep[i]);
      end
    end
  endtask

  task automatic test_mask();
    logic [1:0]  et [4];
    logic [11:0] ep [4];
    et = '{2'd0, 2'd2, 2'd0, 2'd2};
    ep = '{12'h000, 12'h000, 12'h004, 12'h004};
    do_reset(4'b0101);
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (fetch_valid !== 1'b1 || fetch_tid !== et[i] ||
          fetch_pc !== ep[i]) begin
        errors++;
        $display("FAIL mask[%0d] tid=%0d pc=%h want tid=%0d pc=%h",
                 i, fetch_tid, fetch_pc, et[i], ep[i]);
      end
    end
    thread_enable = 4'b0000;
    step(); step();
    checks++;
    if (fetch_valid !== 1'b0) begin
      errors++;
      $display("FAIL none_en v=%b want 0", fetch_valid);
    end
    thread_enable = 4'b0101;
    step();
    checks++;
    if (fetch_valid !== 1'b1 || fetch_tid !== 2'd0 ||
        fetch_pc !== 12'h008) begin
      errors++;
      $display("FAIL frozen tid=%0d pc=%h want tid=0 pc=008",
               fetch_tid, fetch_pc);
    end
  endtask

  task automatic test_stall();
    logic [1:0]  et [4];
    logic [11:0] ep [4];
    et = '{2'd2, 2'd3, 2'd0, 2'd1};
    ep = '{12'h000, 12'h000, 12'h004, 12'h200};
    do_reset(4'b1111);
    step(); step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      redirect_valid = (i == 1);
      redirect_tid   = 2'd1;
      redirect_pc    = 12'h200;
      step();
      checks++;
      if (fetch_valid !== 1'b1 || fetch_tid !== 2'd1 ||
          fetch_pc !== 12'h000 || pc_wrap !== 1'b0) begin
        errors++;
        $display("FAIL stall[%0d] tid=%0d pc=%h want tid=1 pc=000",
                 i, fetch_tid, fetch_pc);
      end
    end
    redirect_valid = 1'b0;
    stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (fetch_tid !== et[i] || fetch_pc !== ep[i]) begin
        errors++;
        $display("FAIL post_stall[%0d] tid=%0d pc=%h want tid=%0d pc=%h",
                 i, fetch_tid, fetch_pc, et[i], ep[i]);
      end
    end
  endtask

  task automatic test_bypass();
    logic [1:0]  et [5];
    logic [11:0] ep [5];
    et = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
    ep = '{12'h300, 12'h000, 12'h004, 12'h004, 12'h304};
    do_reset(4'b1111);
    step(); step();
    redirect_valid = 1'b1;
    redirect_tid   = 2'd2;
    redirect_pc    = 12'h300;
    for (int i = 0; i < 5; i++) begin
      step();
      redirect_valid = 1'b0;
      checks++;
      if (fetch_tid !== et[i] || fetch_pc !== ep[i]) begin
        errors++;
        $display("FAIL bypass[%0d] tid=%0d pc=%h want tid=%0d pc=%h",
                 i, fetch_tid, fetch_pc, et[i], ep[i]);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset(4'b0001);
    redirect_valid = 1'b1;
    redirect_tid   = 2'd0;
    redirect_pc    = 12'hFFC;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (fetch_pc !== 12'hFFC || pc_wrap !== 1'b1) begin
      errors++;
      $display("FAIL wrap_edge pc=%h wrap=%b want FFC 1",
               fetch_pc, pc_wrap);
    end
    step();
    checks++;
    if (fetch_tid !== 2'd0 || fetch_pc !== 12'h000 ||
        pc_wrap !== 1'b0) begin
      errors++;
      $display("FAIL wrap_next tid=%0d pc=%h wrap=%b want 0 000 0",
               fetch_tid, fetch_pc, pc_wrap);
    end
  endtask

  task automatic test_misalign();
    logic [11:0] e0;
    logic [11:0] e1;
`ifdef PC_MISALIGN_TRAP_EN
    e0 = 12'h100; e1 = 12'h104;
`else
    e0 = 12'h200; e1 = 12'h204;
`endif
    do_reset(4'b0001);
    redirect_valid = 1'b1;
    redirect_tid   = 2'd0;
    redirect_pc    = 12'h202;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (fetch_tid !== 2'd0 || fetch_pc !== e0) begin
      errors++;
      $display("FAIL misalign pc=%h want %h", fetch_pc, e0);
    end
`ifdef PC_MISALIGN_TRAP_EN
    checks++;
    if (misalign_trap !== 1'b1) begin
      errors++;
      $display("FAIL trap_pulse got %b want 1", misalign_trap);
    end
`endif
    step();
    checks++;
    if (fetch_pc !== e1) begin
      errors++;
      $display("FAIL misalign_next pc=%h want %h", fetch_pc, e1);
    end
`ifdef PC_MISALIGN_TRAP_EN
    checks++;
    if (misalign_trap !== 1'b0) begin
      errors++;
      $display("FAIL trap_clear got %b want 0", misalign_trap);
    end
`endif
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; thread_enable = '0;
    redirect_valid = 1'b0; redirect_tid = '0; redirect_pc = '0;
    test_reset();
    test_round_robin();
    test_mask();
    test_stall();
    test_bypass();
    test_wrap();
    test_misalign();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
